// File: rtl/speed_pwm_driver.sv
// Motor PWM stage: ramps duty toward the target for the speed level w at a limited slew rate.
// The brake speeds up ramp-down. Duty is latched into the PWM compare only at period boundaries.
module speed_pwm_driver #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned RAMP_DIV  = 16,
    parameter int unsigned DUTY_SLOW = 64,
    parameter int unsigned DUTY_MED  = 128,
    parameter int unsigned DUTY_FAST = 224
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       w,
    input  logic             brake,
    output logic             pwm,
    output logic [CNT_W-1:0] duty,
    output logic [1:0]       state,
    output logic             at_target
);

    typedef enum logic [1:0] {
        StHold = 2'b00,
        StUp   = 2'b01,
        StDown = 2'b10
    } ramp_state_e;

    localparam int unsigned PW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]    PrescLast = PW'(RAMP_DIV - 1);
    // Last count of the 2^CNT_W-1 cycle PWM period.
    localparam logic [CNT_W-1:0] CntLast   = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] duty_active_q, duty_active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             pwm_q, pwm_d;
    logic             tick;
    ramp_state_e      ramp_state;

    always_comb begin
        target_d = '0;
        unique case (w)
            2'b00:   target_d = '0;
            2'b01:   target_d = CNT_W'(DUTY_SLOW);
            2'b10:   target_d = CNT_W'(DUTY_MED);
            default: target_d = CNT_W'(DUTY_FAST);
        endcase
    end

    always_comb begin
        ramp_state = StHold;
        if (duty_q < target_q) begin
            ramp_state = StUp;
        end else if (duty_q > target_q) begin
            ramp_state = StDown;
        end
    end

    assign tick = (presc_q == PrescLast);

    always_comb begin
        presc_d = '0;
        duty_d  = duty_q;
        unique case (ramp_state)
            StUp: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    duty_d = duty_q + 1'b1;
                end
            end
            StDown: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // Brake overrides the slew limit when slowing down.
                if (brake || tick) begin
                    duty_d = duty_q - 1'b1;
                end
            end
            default: begin
                presc_d = '0;
                duty_d  = duty_q;
            end
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q + 1'b1;
        duty_active_d = duty_active_q;
        if (cnt_q == CntLast) begin
            cnt_d         = '0;
            duty_active_d = duty_q;
        end
        pwm_d = (cnt_q < duty_active_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q      <= '0;
            duty_q        <= '0;
            duty_active_q <= '0;
            cnt_q         <= '0;
            presc_q       <= '0;
            pwm_q         <= 1'b0;
        end else begin
            target_q      <= target_d;
            duty_q        <= duty_d;
            duty_active_q <= duty_active_d;
            cnt_q         <= cnt_d;
            presc_q       <= presc_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm       = pwm_q;
    assign duty      = duty_q;
    assign state     = ramp_state;
    assign at_target = (ramp_state == StHold);

endmodule

// File: tb/tb_speed_pwm_driver.sv
// Bench for speed_pwm_driver: cycle-by-cycle comparison against an integer reference model,
// plus directed timing checks for ramp lengths, PWM high time and asynchronous reset.
module tb_speed_pwm_driver;

    localparam int CNT_W    = 8;
    localparam int RAMP_DIV = 4;
    localparam int PERIOD   = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [1:0]       w;
    logic             brake;
    logic             pwm;
    logic [CNT_W-1:0] duty;
    logic [1:0]       state;
    logic             at_target;

    int n_checks;
    int n_pass;

    // Reference model state, plain integers.
    int m_target, m_duty, m_presc, m_cnt, m_dact, m_pwm;

    speed_pwm_driver #(
        .CNT_W    (CNT_W),
        .RAMP_DIV (RAMP_DIV),
        .DUTY_SLOW(64),
        .DUTY_MED (128),
        .DUTY_FAST(224)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .brake    (brake),
        .pwm      (pwm),
        .duty     (duty),
        .state    (state),
        .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int level_duty(input int lvl);
        case (lvl)
            0:       return 0;
            1:       return 64;
            2:       return 128;
            default: return 224;
        endcase
    endfunction

    function automatic int exp_state();
        if (m_duty == m_target) return 0;
        if (m_duty < m_target)  return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_target = 0; m_duty = 0; m_presc = 0; m_cnt = 0; m_dact = 0; m_pwm = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step(input int w_in, input int brake_in);
        int st;
        int tk;
        int n_duty;
        st = exp_state();
        tk = (m_presc == RAMP_DIV - 1);
        n_duty = m_duty;
        if (st == 1 && tk == 1) n_duty = m_duty + 1;
        if (st == 2 && (brake_in == 1 || tk == 1)) n_duty = m_duty - 1;
        m_presc  = (st == 0) ? 0 : (m_presc + 1) % RAMP_DIV;
        m_pwm    = (m_cnt < m_dact) ? 1 : 0;
        if (m_cnt == PERIOD - 1) m_dact = m_duty;
        m_cnt    = (m_cnt + 1) % PERIOD;
        m_duty   = n_duty;
        m_target = level_duty(w_in);
    endtask

    task automatic compare_all();
        check("duty", int'(duty), m_duty);
        check("state", int'(state), exp_state());
        check("at_target", int'(at_target), (m_duty == m_target) ? 1 : 0);
        check("pwm", int'(pwm), m_pwm);
    endtask

    task automatic cyc();
        int w_s;
        int b_s;
        w_s = int'(w);
        b_s = int'(brake);
        @(posedge clk);
        if (reset) model_step(w_s, b_s);
        #1;
        compare_all();
    endtask

    // Count edges until at_target rises again; the first edge always updates target_r.
    task automatic run_to_target(input int bound, output int edges);
        edges = 0;
        do begin
            cyc();
            edges++;
        end while (!(at_target == 1'b1 && edges > 1) && edges < bound);
    endtask

    task automatic count_pwm_high(output int highs);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cyc();
            if (pwm) highs++;
        end
    endtask

    int edges;
    int highs;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        w     = 2'b01;
        brake = 1'b0;
        model_reset();
        #12;
        check("reset_duty", int'(duty), 0);
        check("reset_state", int'(state), 0);
        check("reset_at_target", int'(at_target), 1);
        check("reset_pwm", int'(pwm), 0);
        repeat (2) cyc();

        // Slow ramp from reset: duty 1 after edge 5, settled after edge 257.
        reset = 1'b1;
        cyc();
        check("up_from_edge1", int'(state), 1);
        repeat (3) cyc();
        check("duty_before_edge5", int'(duty), 0);
        cyc();
        check("duty_after_edge5", int'(duty), 1);
        edges = 5;
        while (at_target !== 1'b1 && edges < 2000) begin
            cyc();
            edges++;
        end
        check("slow_ramp_edges", edges, 1 + 64 * RAMP_DIV);
        check("slow_ramp_duty", int'(duty), 64);

        repeat (PERIOD + 50) cyc();
        count_pwm_high(highs);
        check("pwm_high_64", highs, 64);

        // Ramp to medium, then braked ramp-down to slow.
        w = 2'b10;
        run_to_target(2000, edges);
        check("med_ramp_edges", edges, 1 + 64 * RAMP_DIV);
        w = 2'b01;
        brake = 1'b1;
        run_to_target(2000, edges);
        check("brake_down_edges", edges, 1 + 64);
        check("brake_down_duty", int'(duty), 64);

        // Down to stop; PWM must go constant low.
        w = 2'b00;
        run_to_target(2000, edges);
        check("stop_edges", edges, 1 + 64);
        repeat (PERIOD + 10) cyc();
        count_pwm_high(highs);
        check("pwm_high_0", highs, 0);

        // Brake is ignored while ramping up.
        w = 2'b11;
        brake = 1'b1;
        run_to_target(5000, edges);
        check("brake_up_edges", edges, 1 + 224 * RAMP_DIV);
        check("fast_duty", int'(duty), 224);
        w = 2'b00;
        run_to_target(2000, edges);
        check("fast_to_stop_edges", edges, 1 + 224);

        // Reversal at duty 40 while ramping toward medium.
        w = 2'b10;
        brake = 1'b0;
        edges = 0;
        while (duty != 8'd40 && edges < 2000) begin
            cyc();
            edges++;
        end
        check("reach_40", int'(duty), 40);
        w = 2'b00;
        cyc();
        check("reverse_state", int'(state), 2);
        run_to_target(2000, edges);
        check("reverse_duty", int'(duty), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) w = 2'($urandom_range(0, 3));
            brake = ($urandom_range(0, 3) == 0);
            cyc();
        end

        // Mid-ramp asynchronous reset at duty 100.
        w = 2'b00;
        brake = 1'b1;
        run_to_target(2000, edges);
        w = 2'b10;
        brake = 1'b0;
        edges = 0;
        while (duty != 8'd100 && edges < 2000) begin
            cyc();
            edges++;
        end
        check("reach_100", int'(duty), 100);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_duty", int'(duty), 0);
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_state", int'(state), 0);
        check("async_rst_at_target", int'(at_target), 1);
        repeat (3) cyc();
        check("held_rst_duty", int'(duty), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
